dynvc_credit_tracker: RTL
=========================

DYNVC_CREDIT_TRACKER -- requirements
Module: dynvc_credit_tracker

Interface
REQ-001 SHALL have parameter max_vc_number, default 10, number of VCs sharing one downstream memory bank.
REQ-002 SHALL have parameter memory_bank_depth, default 32, downstream shared bank capacity in flits.
REQ-003 SHALL define cnt_width = clogb(memory_bank_depth+1) for all counters.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flit_sent  input  1  a flit leaves this port toward the downstream bank this cycle.
REQ-007 SHALL have port flit_vc  input  max_vc_number  one-hot VC of the sent flit; [0:max_vc_number-1] ordering.
REQ-008 SHALL have port credit_valid  input  1  downstream freed one slot this cycle.
REQ-009 SHALL have port credit_vc  input  max_vc_number  one-hot VC the returned credit belongs to.
REQ-010 SHALL have port vc_ready  output  max_vc_number  bit v high = one more flit on VC v is accepted downstream.
REQ-011 SHALL have port vc_empty  output  max_vc_number  bit v high = VC v has zero flits outstanding downstream.
REQ-012 SHALL have port free_count  output  cnt_width  free shared slots.
REQ-013 SHALL have port error  output  1  sticky protocol-violation flag.

Function
REQ-014 SHALL keep one occupancy counter occ[v] per VC and one shared free counter free.
REQ-015 SHALL derive all outputs from registered state only; no combinational input-to-output path.
REQ-016 SHALL apply an accepted send at the clock edge: occ[v] +1, free -1, with the result visible the next cycle.
REQ-017 SHALL apply an accepted credit at the clock edge: occ[v] -1, free +1, with the result visible the next cycle.
REQ-018 SHALL leave occ[v] and free unchanged when a send and a credit on the same VC occur in one cycle.
REQ-019 SHALL apply a send and a credit on different VCs in the same cycle independently, with a net free change of 0.
REQ-020 SHALL treat vc_ready[v] = (free > 0) when the reserve feature is absent.
REQ-021 SHALL drive vc_empty[v] = (occ[v] == 0).
REQ-022 SHALL ignore a send when flit_vc is not one-hot or the target vc_ready bit is low: no counter change, error set.
REQ-023 SHALL ignore a credit when credit_vc is not one-hot, the target occ[v] is 0, or free is at its maximum: no counter change, error set.
REQ-024 SHALL still apply a legal event when the other event in the same cycle is illegal.
REQ-025 SHALL saturate no counter silently; every out-of-range step is rejected per REQ-022/REQ-023.

Reset
REQ-026 SHALL, while reset is low, force occ[v]=0, error=0, and free to its initial value (REQ-028/REQ-029).
REQ-027 SHALL, under reset, drive vc_empty all ones, and drive vc_ready all ones when memory_bank_depth>0; a reset mid-traffic discards all outstanding state.

Configuration
REQ-028 SHALL, without macro DYNVC_RESERVED_SLOT_EN, treat all memory_bank_depth slots as shared, with free reset value = memory_bank_depth.
REQ-029 SHALL, with DYNVC_RESERVED_SLOT_EN defined, reserve one slot per VC, with free = shared pool only and a reset value of memory_bank_depth - max_vc_number.
REQ-030 SHALL, with DYNVC_RESERVED_SLOT_EN, drive vc_ready[v] = (occ[v]==0) | (free>0).
REQ-031 SHALL, with DYNVC_RESERVED_SLOT_EN, not decrement free on a send to a VC with occ==0 (reserved slot used).
REQ-032 SHALL, with DYNVC_RESERVED_SLOT_EN, not increment free on a credit to a VC with occ==1 (reserved slot returned).
REQ-033 SHALL, with DYNVC_RESERVED_SLOT_EN, leave the REQ-018 same-VC simultaneous rule unchanged.

Verification
REQ-034 SHALL verify reset release with defaults and no macro: free_count=32, vc_ready=all 1s, vc_empty=all 1s, error=0.
REQ-035 SHALL verify fill: 32 sends on VC0 -> occ0=32, free_count=0, vc_ready=0 next cycle; a 33rd send -> ignored, error=1.
REQ-036 SHALL verify a same-cycle send VC3 + credit VC3 with occ3=2 -> occ3=2, free unchanged, error=0.
REQ-037 SHALL verify a credit on VC5 with occ5=0 -> counters unchanged, error=1 and held until reset.
REQ-038 SHALL verify, with DYNVC_RESERVED_SLOT_EN, 22 sends on VC0 then 1 send each on VC1..VC9: free_count=22 after reset, 1 after the VC0 sends (first send uses the reserve), then stays 1, with all vc_ready still high.
REQ-039 SHALL verify reset asserted mid-traffic (occ1=7) -> all counters return to their reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/dynvc_credit_tracker.sv
// Credit tracker for VCs that share one downstream memory bank: per-VC occupancy plus a shared free-slot pool.
// Optional macro DYNVC_RESERVED_SLOT_EN reserves one bank slot per VC outside the shared pool.
module dynvc_credit_tracker #(
  parameter int max_vc_number     = 10,
  parameter int memory_bank_depth = 32,
  localparam int cnt_width        = $clog2(memory_bank_depth + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flit_sent,
  input  logic [0:max_vc_number-1] flit_vc,
  input  logic                     credit_valid,
  input  logic [0:max_vc_number-1] credit_vc,
  output logic [0:max_vc_number-1] vc_ready,
  output logic [0:max_vc_number-1] vc_empty,
  output logic [cnt_width-1:0]     free_count,
  output logic                     error
);

`ifdef DYNVC_RESERVED_SLOT_EN
  localparam int   free_init  = memory_bank_depth - max_vc_number;
  localparam logic reserve_en = 1'b1;
`else
  localparam int   free_init  = memory_bank_depth;
  localparam logic reserve_en = 1'b0;
`endif

  localparam logic [cnt_width-1:0]     cnt_zero   = {cnt_width{1'b0}};
  localparam logic [cnt_width-1:0]     cnt_one    = {{(cnt_width-1){1'b0}}, 1'b1};
  localparam logic [cnt_width-1:0]     free_max   = cnt_width'(free_init);
  localparam logic [0:max_vc_number-1] vc_ones    = {max_vc_number{1'b1}};
  localparam logic [0:max_vc_number-1] vc_zeros   = {max_vc_number{1'b0}};
  localparam logic [0:max_vc_number-1] ready_init =
    (reserve_en || (memory_bank_depth > 0)) ? vc_ones : vc_zeros;

  function automatic logic is_onehot(input logic [0:max_vc_number-1] vec);
    int unsigned ones;
    ones = 32'd0;
    for (int i = 0; i < max_vc_number; i++) begin
      ones = ones + 32'(vec[i]);
    end
    return (ones == 32'd1);
  endfunction

  // A VC with nothing outstanding can always use its own reserved slot when reservation is built in.
  function automatic logic ready_of(input logic [cnt_width-1:0] occ, input logic [cnt_width-1:0] free);
    return reserve_en ? ((occ == cnt_zero) || (free != cnt_zero)) : (free != cnt_zero);
  endfunction

  logic [cnt_width-1:0]     occ_r        [0:max_vc_number-1];
  logic [cnt_width-1:0]     occ_next_s   [0:max_vc_number-1];
  logic [cnt_width-1:0]     free_r;
  logic [cnt_width-1:0]     free_next_s;
  logic                     error_r;
  logic                     error_next_s;
  logic [0:max_vc_number-1] ready_r;
  logic [0:max_vc_number-1] ready_next_s;
  logic [0:max_vc_number-1] empty_r;
  logic [0:max_vc_number-1] empty_next_s;
  logic                     send_onehot_s;
  logic                     credit_onehot_s;
  logic [0:max_vc_number-1] send_acc_s;
  logic [0:max_vc_number-1] credit_acc_s;
  logic [0:max_vc_number-1] take_mask_s;
  logic [0:max_vc_number-1] give_mask_s;
  logic                     take_s;
  logic                     give_s;
  logic                     send_err_s;
  logic                     credit_err_s;

  // Event legality: each event is judged on its own against the current registered state.
  always_comb begin
    send_onehot_s   = is_onehot(flit_vc);
    credit_onehot_s = is_onehot(credit_vc);
    for (int v = 0; v < max_vc_number; v++) begin
      take_mask_s[v]  = reserve_en ? (occ_r[v] != cnt_zero) : 1'b1;
      give_mask_s[v]  = reserve_en ? (occ_r[v] != cnt_one)  : 1'b1;
      send_acc_s[v]   = flit_sent & send_onehot_s & flit_vc[v] & ready_r[v];
      credit_acc_s[v] = credit_valid & credit_onehot_s & credit_vc[v] &
                        (occ_r[v] != cnt_zero) & ~(give_mask_s[v] & (free_r == free_max));
    end
    send_err_s   = flit_sent & ~(|send_acc_s);
    credit_err_s = credit_valid & ~(|credit_acc_s);
    // A send and credit accepted on the same VC cancel, so neither touches the pool.
    take_s       = |(send_acc_s & ~credit_acc_s & take_mask_s);
    give_s       = |(credit_acc_s & ~send_acc_s & give_mask_s);
  end

  // Next-state values for counters, sticky error and the registered status outputs.
  always_comb begin
    free_next_s = free_r;
    case ({take_s, give_s})
      2'b10:   free_next_s = free_r - cnt_one;
      2'b01:   free_next_s = free_r + cnt_one;
      default: free_next_s = free_r;
    endcase
    error_next_s = error_r | send_err_s | credit_err_s;
    for (int v = 0; v < max_vc_number; v++) begin
      occ_next_s[v] = occ_r[v];
      case ({send_acc_s[v], credit_acc_s[v]})
        2'b10:   occ_next_s[v] = occ_r[v] + cnt_one;
        2'b01:   occ_next_s[v] = occ_r[v] - cnt_one;
        default: occ_next_s[v] = occ_r[v];
      endcase
      empty_next_s[v] = (occ_next_s[v] == cnt_zero);
      ready_next_s[v] = ready_of(occ_next_s[v], free_next_s);
    end
  end

  // State and output registers; reset discards all outstanding credit state immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < max_vc_number; v++) begin
        occ_r[v] <= cnt_zero;
      end
      free_r  <= free_max;
      error_r <= 1'b0;
      ready_r <= ready_init;
      empty_r <= vc_ones;
    end else begin
      for (int v = 0; v < max_vc_number; v++) begin
        occ_r[v] <= occ_next_s[v];
      end
      free_r  <= free_next_s;
      error_r <= error_next_s;
      ready_r <= ready_next_s;
      empty_r <= empty_next_s;
    end
  end

  assign vc_ready   = ready_r;
  assign vc_empty   = empty_r;
  assign free_count = free_r;
  assign error      = error_r;

endmodule
